dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data cache controller between the 8-bit CPU load/store path and the block-organised data memory. It sits on the CPU's ALU-address/register-write path. It serves byte accesses out of an 8-entry × 4-byte array. On a miss it sequences block write-back and fetch over a busy-wait memory handshake, and stalls the CPU through BUSYWAIT until the access can complete.

---
 rtl/dcache_ctrl.sv | 92 +++++++++
 tb/tb_dcache_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache: 8 sets x 4-byte blocks.
// Byte access for the CPU; block write-back and fetch over a busy-wait memory handshake.
module dcache_ctrl (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

  state_t      state, state_nxt;
  logic [7:0]  valid, dirty;
  logic [2:0]  tag_q  [8];
  logic [31:0] data_q [8];

  logic [2:0] idx, tag_in;
  logic [1:0] off;
  logic       req, hit;

  assign tag_in = ADDRESS[7:5];
  assign idx    = ADDRESS[4:2];
  assign off    = ADDRESS[1:0];
  assign req    = READ | WRITE;
  assign hit    = valid[idx] && (tag_q[idx] == tag_in);

  // Data is presented unconditionally; the CPU only consumes it once BUSYWAIT is low.
  assign READDATA = data_q[idx][{off, 3'b000} +: 8];

  always_comb begin
    state_nxt     = state;
    BUSYWAIT      = req && !(state == IDLE && hit);
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = 6'd0;
    MEM_WRITEDATA = 32'd0;
    case (state)
      IDLE: begin
        if (req && !hit) state_nxt = dirty[idx] ? WRITEBACK : FETCH;
      end
      WRITEBACK: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tag_q[idx], idx};
        MEM_WRITEDATA = data_q[idx];
        if (!MEM_BUSYWAIT) state_nxt = FETCH;
      end
      FETCH: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {tag_in, idx};
        if (!MEM_BUSYWAIT) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Any edge sampled inside WRITEBACK/FETCH already follows a full cycle there,
  // so MEM_BUSYWAIT low alone marks completion.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid <= '0;
      dirty <= '0;
      for (int i = 0; i < 8; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (state == FETCH && !MEM_BUSYWAIT) begin
      data_q[idx] <= MEM_READDATA;
      tag_q[idx]  <= tag_in;
      valid[idx]  <= 1'b1;
      dirty[idx]  <= 1'b0;
    end else if (state == IDLE && WRITE && hit) begin
      data_q[idx][{off, 3'b000} +: 8] <= WRITEDATA;
      dirty[idx]                      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: transaction-level cache/memory model predicts every cycle's
// outputs; a negedge process compares, plus literal checks pinning the model.
module tb_dcache_ctrl;

  logic        CLK = 1'b0;
  logic        RESET, READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA, READDATA;
  logic        BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA, MEM_READDATA;

  dcache_ctrl dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Memory device: busy for mem_lat cycles of an active request, then done.
  logic [31:0] mem [64];
  int          mem_lat = 0;
  int          mcnt    = 0;
  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mcnt < mem_lat);
  assign MEM_READDATA = mem[MEM_ADDRESS];

  initial begin
    for (int i = 0; i < 64; i++)
      mem[i] = {8'(i), 8'hA5 ^ 8'(i), 8'h3C, 8'(i * 3)};
    mem[6'h00] = 32'hDDCCBBAA;
    mem[6'h08] = 32'h44332211;
    mem[6'h39] = 32'h12345678;
    mem[6'h10] = 32'h9988CC66;
    forever begin
      @(posedge CLK);
      if ((MEM_READ | MEM_WRITE) && MEM_BUSYWAIT) mcnt <= mcnt + 1;
      else                                        mcnt <= 0;
      if (MEM_WRITE && !MEM_BUSYWAIT) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
    end
  end

  // Reference model state
  logic [7:0]  m_valid, m_dirty;
  logic [2:0]  m_tag  [8];
  logic [31:0] m_data [8];
  logic [31:0] m_mem  [64];

  // Per-cycle expectations
  logic        chk_on = 1'b0;
  logic        e_busy, e_mr, e_mw;
  logic [7:0]  e_rd;
  logic [5:0]  e_ma;
  logic [31:0] e_mwd;
  int          busy_cnt;
  logic [5:0]  wb_addr, fe_addr;
  logic [31:0] wb_data;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] o);
    return w[{o, 3'b000} +: 8];
  endfunction

  task automatic set_exp(input logic b, input logic [7:0] rd, input logic mr, input logic mw,
                         input logic [5:0] ma, input logic [31:0] mwd);
    e_busy = b; e_rd = rd; e_mr = mr; e_mw = mw; e_ma = ma; e_mwd = mwd;
  endtask

  task automatic idle_exp;
    set_exp(1'b0, byte_of(m_data[ADDRESS[4:2]], ADDRESS[1:0]), 1'b0, 1'b0, 6'd0, 32'd0);
  endtask

  task automatic step;
    @(posedge CLK); #1;
  endtask

  task automatic model_reset;
    m_valid = '0; m_dirty = '0;
    for (int i = 0; i < 8; i++) begin m_tag[i] = '0; m_data[i] = '0; end
  endtask

  always @(negedge CLK) begin
    if (chk_on) begin
      check("busywait",      BUSYWAIT,      e_busy);
      check("readdata",      READDATA,      e_rd);
      check("mem_read",      MEM_READ,      e_mr);
      check("mem_write",     MEM_WRITE,     e_mw);
      check("mem_address",   MEM_ADDRESS,   e_ma);
      check("mem_writedata", MEM_WRITEDATA, e_mwd);
      if (BUSYWAIT)  busy_cnt++;
      if (MEM_WRITE) begin wb_addr = MEM_ADDRESS; wb_data = MEM_WRITEDATA; end
      if (MEM_READ)  fe_addr = MEM_ADDRESS;
    end
  end

  // One CPU access from request to the cycle it completes; starts just after an edge.
  task automatic access(input bit wr, input logic [7:0] a, input logic [7:0] wd, input int lat);
    logic [2:0] ix, t;
    logic [1:0] o;
    bit         h;
    ix = a[4:2]; t = a[7:5]; o = a[1:0];
    busy_cnt = 0;
    READ = !wr; WRITE = wr; ADDRESS = a; WRITEDATA = wd; mem_lat = lat;
    h = m_valid[ix] && (m_tag[ix] == t);
    if (!h) begin
      set_exp(1'b1, byte_of(m_data[ix], o), 1'b0, 1'b0, 6'd0, 32'd0);
      step;
      if (m_dirty[ix]) begin
        repeat (lat + 1) begin
          set_exp(1'b1, byte_of(m_data[ix], o), 1'b0, 1'b1, {m_tag[ix], ix}, m_data[ix]);
          step;
        end
        m_mem[{m_tag[ix], ix}] = m_data[ix];
      end
      repeat (lat + 1) begin
        set_exp(1'b1, byte_of(m_data[ix], o), 1'b1, 1'b0, {t, ix}, 32'd0);
        step;
      end
      m_data[ix] = m_mem[{t, ix}]; m_tag[ix] = t; m_valid[ix] = 1'b1; m_dirty[ix] = 1'b0;
    end
    set_exp(1'b0, byte_of(m_data[ix], o), 1'b0, 1'b0, 6'd0, 32'd0);
    step;
    if (wr) begin m_data[ix][{o, 3'b000} +: 8] = wd; m_dirty[ix] = 1'b1; end
    READ = 1'b0; WRITE = 1'b0;
    idle_exp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RESET = 1'b0; READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
    for (int i = 0; i < 64; i++)
      m_mem[i] = {8'(i), 8'hA5 ^ 8'(i), 8'h3C, 8'(i * 3)};
    m_mem[6'h00] = 32'hDDCCBBAA;
    m_mem[6'h08] = 32'h44332211;
    m_mem[6'h39] = 32'h12345678;
    m_mem[6'h10] = 32'h9988CC66;
    model_reset;

    // Reset state, with clock edges occurring while held
    #1;
    check("rst_busywait", BUSYWAIT,  1'b1);
    check("rst_readdata", READDATA,  8'h00);
    check("rst_mem_req",  {MEM_READ, MEM_WRITE}, 2'b00);
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busywait_clk", BUSYWAIT,    1'b1);
    check("rst_mem_addr",     MEM_ADDRESS, 6'd0);
    READ = 1'b0;
    step;
    RESET = 1'b1;
    idle_exp;
    chk_on = 1'b1;
    step;

    // Clean miss, L = 2: stall 1 + 2 + 1
    access(0, 8'h00, 8'h00, 2);
    check("miss_busy_cycles", busy_cnt, 4);
    check("miss_fetch_addr",  fe_addr,  6'h00);
    check("miss_rdata",       READDATA, 8'hAA);

    // Read hits
    access(0, 8'h01, 8'h00, 3);
    check("hit1_busy", busy_cnt, 0);
    access(0, 8'h02, 8'h00, 3);
    access(0, 8'h03, 8'h00, 3);
    check("hit3_rdata", READDATA, 8'hDD);
    check("hit3_busy",  busy_cnt, 0);

    // Write hit then read back
    access(1, 8'h02, 8'h5A, 3);
    check("whit_busy", busy_cnt, 0);
    access(0, 8'h02, 8'h00, 3);
    check("whit_rdata", READDATA, 8'h5A);

    // Dirty miss, L = 1: write-back then fetch
    access(0, 8'h20, 8'h00, 1);
    check("wb_addr",       wb_addr,    6'h00);
    check("wb_data",       wb_data,    32'hDD5ABBAA);
    check("wb_mem",        mem[6'h00], 32'hDD5ABBAA);
    check("dmiss_fetch",   fe_addr,    6'h08);
    check("dmiss_busy",    busy_cnt,   5);
    check("dmiss_rdata",   READDATA,   8'h11);

    // Write-allocate miss on clean set 1, L = 3
    access(1, 8'hE7, 8'h77, 3);
    check("walloc_fetch", fe_addr,  6'h39);
    check("walloc_busy",  busy_cnt, 5);
    access(0, 8'hE7, 8'h00, 0);
    check("walloc_rdata", READDATA, 8'h77);

    // Reset asserted mid-fetch
    READ = 1'b1; ADDRESS = 8'h40; mem_lat = 5;
    set_exp(1'b1, byte_of(m_data[0], 2'd0), 1'b0, 1'b0, 6'd0, 32'd0);
    step;
    set_exp(1'b1, byte_of(m_data[0], 2'd0), 1'b1, 1'b0, 6'h10, 32'd0);
    step;
    step;
    #2;
    chk_on = 1'b0;
    RESET = 1'b0;
    #1;
    check("midrst_mem_read", MEM_READ,    1'b0);
    check("midrst_mem_addr", MEM_ADDRESS, 6'd0);
    check("midrst_busywait", BUSYWAIT,    1'b1);
    check("midrst_readdata", READDATA,    8'h00);
    READ = 1'b0;
    model_reset;
    step;
    RESET = 1'b1;
    idle_exp;
    chk_on = 1'b1;
    step;

    access(0, 8'h40, 8'h00, 0);
    check("postrst_busy",  busy_cnt, 2);
    check("postrst_rdata", READDATA, 8'h66);
    access(0, 8'h00, 8'h00, 0);
    check("postrst_busy0", busy_cnt, 2);
    check("postrst_rd0",   READDATA, 8'hAA);
    step;

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
